vx_pending_counter: RTL and testbench
=====================================

# vx_pending_counter

Parametrised outstanding-item counter that generalises the single-step pending-size tracker. Each cycle it accepts a multi-unit increment and a multi-unit decrement, applies their net effect, and drives registered occupancy flags. Flags are empty, full, programmable almost-empty and almost-full. It also provides a free-space count and sticky overflow/underflow error flags. It sits beside request/response queues (memory schedulers, LSU pending tables, multi-issue dispatch credits), where several requests may issue or retire in one cycle.

## Interface
- SIZE, 4: maximum count; ≥1.
- INCRW, 1: width of increment amount; ≥1.
- DECRW, 1: width of decrement amount; ≥1.
- ALM_FULL, SIZE-1: alm_full threshold; 1 ≤ ALM_FULL ≤ SIZE.
- ALM_EMPTY, 1: alm_empty threshold; 0 ≤ ALM_EMPTY < SIZE.
- SIZEW, $clog2(SIZE+1): width of size/space.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- incr  in  INCRW  units added this cycle (0 = none).
- decr  in  DECRW  units removed this cycle (0 = none).
- flush  in  1  clears count to 0 this cycle.
- size  out  SIZEW  current count.
- space  out  SIZEW  SIZE - size.
- empty  out  1  size == 0.
- full  out  1  size == SIZE.
- alm_empty  out  1  size ≤ ALM_EMPTY.
- alm_full  out  1  size ≥ ALM_FULL.
- ovf_err  out  1  sticky: an update exceeded SIZE.
- unf_err  out  1  sticky: an update went below 0.

## Operation
- Net update: nxt = size + incr - decr.
  - Evaluate in signed width max(SIZEW,INCRW,DECRW)+2 so there is no wrap.
  - decr is checked against size+incr. A same-cycle increment covers a same-cycle decrement (bypass).
- Overflow: nxt > SIZE → size saturates to SIZE; ovf_err set.
- Underflow: nxt < 0 → size clamps to 0; unf_err set.
- Both error flags stay set until reset. Neither flush nor later legal traffic clears them.
- flush=1:
  - Next size is 0, regardless of incr/decr.
  - No ovf/unf evaluation that cycle.
  - Flags update to empty state.
- incr=decr≠0 with no flush: size unchanged, even at full or empty. This is not an error.
- All outputs come from registers.
  - Flags and space are computed from nxt and registered alongside size, so no output has a combinational path from inputs.
  - space, empty, full, alm_empty and alm_full are always consistent with size in the same cycle.
- Simulation-only assertions:
  - no update ever sets ovf_err or unf_err outside the error tests;
  - ALM_FULL and ALM_EMPTY are within range at elaboration.

## Timing
- Reset values:
  - size = 0, space = SIZE;
  - empty = 1, full = 0;
  - alm_empty = 1, alm_full = 0;
  - ovf_err = 0, unf_err = 0.
- Latency:
  - inputs sampled at edge N; size and all flags reflect them after edge N (visible in cycle N+1);
  - back-to-back updates every cycle; no stall, no handshake.
- reset takes priority over flush, incr and decr. Reset mid-traffic discards that cycle's update.
- flush takes priority over incr and decr.
- Error flags assert in the same cycle that size shows the saturated or clamped value.
- Single-step use (INCRW=DECRW=1) is cycle-identical to the existing pending-size tracker.
  - empty, full and size then match it exactly.
  - full is never silently wrapped; saturation plus ovf_err replaces the runtime assert.

## Test plan
- SIZE=8, INCRW=DECRW=4, ALM_FULL=6, ALM_EMPTY=2:
  - after reset → size=0, space=8, empty=1, alm_empty=1, all others 0;
  - incr=3 for one cycle → next cycle size=3, space=5, empty=0, alm_empty=0.
- Same config from size=3:
  - incr=3, decr=0 → size=6, alm_full=1;
  - then incr=2 → size=8, full=1, space=0, ovf_err=0.
- From size=8:
  - incr=2, decr=2 → size stays 8, no error;
  - then incr=1 → size=8, ovf_err=1;
  - then decr=8 → size=0, empty=1, ovf_err still 1.
- From size=1:
  - incr=1, decr=2 → size=0, no unf_err (bypass);
  - then decr=1 → size=0, unf_err=1.
- From size=5:
  - flush=1 with incr=4 → size=0, empty=1, no errors;
  - reset asserted in the same cycle as incr=4 → size=0, all flags at reset values.
- SIZE=1, INCRW=DECRW=1, random incr/decr for 10k cycles with the full-incr constraint → size/empty/full match a reference model cycle-for-cycle; errors never set.

Source files
------------

// File: rtl/vx_pending_counter.sv
// Outstanding-item counter with multi-unit increment/decrement per cycle, registered
// occupancy flags, free-space count and sticky overflow/underflow error flags.
module vx_pending_counter #(
    parameter int SIZE         = 4,
    parameter int INCRW        = 1,
    parameter int DECRW        = 1,
    parameter int ALM_FULL     = SIZE - 1,
    parameter int ALM_EMPTY    = 1,
    parameter int SIZEW        = $clog2(SIZE + 1),
    parameter bit CHECK_NO_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INCRW-1:0] incr,
    input  logic [DECRW-1:0] decr,
    input  logic             flush,
    output logic [SIZEW-1:0] size,
    output logic [SIZEW-1:0] space,
    output logic             empty,
    output logic             full,
    output logic             alm_empty,
    output logic             alm_full,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int MW = (SIZEW > INCRW) ? ((SIZEW > DECRW) ? SIZEW : DECRW)
                                        : ((INCRW > DECRW) ? INCRW : DECRW);
    // Two guard bits: one for the carry of size+incr, one for the sign.
    localparam int CW = MW + 2;

    if ((ALM_FULL < 1) || (ALM_FULL > SIZE) || (ALM_EMPTY < 0) || (ALM_EMPTY >= SIZE) || (SIZE < 1))
    begin : g_bad_param
        $error("vx_pending_counter: threshold parameters out of range");
    end

    logic [CW-1:0]    sum;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic [SIZEW-1:0] size_nxt;

    always_comb begin
        sum      = CW'(size) + CW'(incr) - CW'(decr);
        ovf_nxt  = 1'b0;
        unf_nxt  = 1'b0;
        size_nxt = SIZEW'(sum);
        if (flush) begin
            size_nxt = '0;
        end else if (sum[CW-1]) begin
            unf_nxt  = 1'b1;
            size_nxt = '0;
        end else if (sum > CW'(SIZE)) begin
            ovf_nxt  = 1'b1;
            size_nxt = SIZEW'(SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            size      <= '0;
            space     <= SIZEW'(SIZE);
            empty     <= 1'b1;
            full      <= 1'b0;
            alm_empty <= 1'b1;
            alm_full  <= 1'b0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
        end else begin
            size      <= size_nxt;
            space     <= SIZEW'(SIZE) - size_nxt;
            empty     <= (size_nxt == '0);
            full      <= (size_nxt == SIZEW'(SIZE));
            alm_empty <= (size_nxt <= SIZEW'(ALM_EMPTY));
            alm_full  <= (size_nxt >= SIZEW'(ALM_FULL));
            ovf_err   <= ovf_err | ovf_nxt;
            unf_err   <= unf_err | unf_nxt;
            if (CHECK_NO_ERR) begin
                assert (!(ovf_nxt || unf_nxt));
            end
        end
    end

endmodule

// File: tb/tb_vx_pending_counter.sv
// Bench for vx_pending_counter: directed vector table and random traffic on an
// 8-deep multi-unit instance, plus constrained single-step random on a 1-deep instance.
module tb_vx_pending_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- instance A: SIZE=8, INCRW=DECRW=4, ALM_FULL=6, ALM_EMPTY=2
    logic       a_reset, a_flush;
    logic [3:0] a_incr, a_decr;
    logic [3:0] a_size, a_space;
    logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;

    vx_pending_counter #(.SIZE(8), .INCRW(4), .DECRW(4), .ALM_FULL(6), .ALM_EMPTY(2)) dut_a (
        .clk(clk), .reset(a_reset), .incr(a_incr), .decr(a_decr), .flush(a_flush),
        .size(a_size), .space(a_space), .empty(a_empty), .full(a_full),
        .alm_empty(a_ae), .alm_full(a_af), .ovf_err(a_ovf), .unf_err(a_unf)
    );

    // ---- instance B: SIZE=1 single-step, errors must never occur
    logic       b_reset, b_flush;
    logic [0:0] b_incr, b_decr;
    logic [0:0] b_size, b_space;
    logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;

    vx_pending_counter #(.SIZE(1), .INCRW(1), .DECRW(1), .ALM_FULL(1), .ALM_EMPTY(0),
                         .CHECK_NO_ERR(1'b1)) dut_b (
        .clk(clk), .reset(b_reset), .incr(b_incr), .decr(b_decr), .flush(b_flush),
        .size(b_size), .space(b_space), .empty(b_empty), .full(b_full),
        .alm_empty(b_ae), .alm_full(b_af), .ovf_err(b_ovf), .unf_err(b_unf)
    );

    // Expected output bundle for A: {size, space, empty, full, alm_empty, alm_full, ovf, unf}
    typedef struct {
        logic        rst;
        logic        fl;
        logic [3:0]  inc;
        logic [3:0]  dec;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] a_bundle();
        return {a_size, a_space, a_empty, a_full, a_ae, a_af, a_ovf, a_unf};
    endfunction

    function automatic logic [13:0] exp_a(int s, bit ovf, bit unf);
        logic [3:0] sz;
        logic [3:0] sp;
        sz = 4'(s);
        sp = 4'(8 - s);
        return {sz, sp, s == 0, s == 8, s <= 2, s >= 6, ovf, unf};
    endfunction

    function automatic vec_t mk(logic rst, logic fl, int inc, int dec, logic [13:0] exp);
        vec_t v;
        v.rst = rst; v.fl = fl; v.inc = 4'(inc); v.dec = 4'(dec); v.exp = exp;
        return v;
    endfunction

    task automatic apply_a(logic rst, logic fl, logic [3:0] inc, logic [3:0] dec);
        a_reset = rst; a_flush = fl; a_incr = inc; a_decr = dec;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(string name, logic [13:0] exp);
        checks++;
        if (a_bundle() !== exp) begin
            errors++;
            $display("FAIL %s: got {size,space,e,f,ae,af,ovf,unf}=%b required %b", name, a_bundle(), exp);
        end
    endtask

    // Reference model: plain saturating integer arithmetic with sticky error bits.
    int  m_size;
    bit  m_ovf, m_unf;

    task automatic model_step(int cap, bit rst, bit fl, int inc, int dec);
        int n;
        if (rst) begin
            m_size = 0; m_ovf = 0; m_unf = 0;
        end else if (fl) begin
            m_size = 0;
        end else begin
            n = m_size + inc - dec;
            if (n > cap) begin m_size = cap; m_ovf = 1; end
            else if (n < 0) begin m_size = 0; m_unf = 1; end
            else m_size = n;
        end
    endtask

    vec_t vecs[$];

    initial begin
        a_reset = 1; a_flush = 0; a_incr = 0; a_decr = 0;
        b_reset = 1; b_flush = 0; b_incr = 0; b_decr = 0;
        @(posedge clk); #1;

        // Directed table: each entry's expectation is the state after that cycle.
        vecs.push_back(mk(1, 0, 0, 0, exp_a(0, 0, 0)));   // reset values
        vecs.push_back(mk(0, 0, 3, 0, exp_a(3, 0, 0)));   // first increment
        vecs.push_back(mk(0, 0, 3, 0, exp_a(6, 0, 0)));   // reaches alm_full
        vecs.push_back(mk(0, 0, 2, 0, exp_a(8, 0, 0)));   // exactly full, no error
        vecs.push_back(mk(0, 0, 2, 2, exp_a(8, 0, 0)));   // balanced at full
        vecs.push_back(mk(0, 0, 1, 0, exp_a(8, 1, 0)));   // overflow saturates
        vecs.push_back(mk(0, 0, 0, 8, exp_a(0, 1, 0)));   // drain, ovf sticky
        vecs.push_back(mk(0, 0, 1, 0, exp_a(1, 1, 0)));
        vecs.push_back(mk(0, 0, 1, 2, exp_a(0, 1, 0)));   // bypass, no underflow
        vecs.push_back(mk(0, 0, 0, 1, exp_a(0, 1, 1)));   // underflow clamps
        vecs.push_back(mk(1, 0, 0, 0, exp_a(0, 0, 0)));   // reset clears sticky flags
        vecs.push_back(mk(0, 0, 5, 0, exp_a(5, 0, 0)));
        vecs.push_back(mk(0, 1, 4, 0, exp_a(0, 0, 0)));   // flush beats incr
        vecs.push_back(mk(0, 0, 4, 0, exp_a(4, 0, 0)));
        vecs.push_back(mk(1, 0, 4, 0, exp_a(0, 0, 0)));   // reset beats incr
        vecs.push_back(mk(0, 0, 15, 0, exp_a(8, 1, 0)));  // large overflow
        vecs.push_back(mk(0, 1, 0, 15, exp_a(0, 1, 0)));  // flush: no unf, ovf kept
        vecs.push_back(mk(0, 0, 2, 0, exp_a(2, 1, 0)));   // alm_empty boundary
        vecs.push_back(mk(0, 0, 1, 0, exp_a(3, 1, 0)));
        vecs.push_back(mk(0, 0, 15, 15, exp_a(3, 1, 0))); // max balanced traffic

        for (int i = 0; i < vecs.size(); i++) begin
            apply_a(vecs[i].rst, vecs[i].fl, vecs[i].inc, vecs[i].dec);
            check_a($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Hand-written: balanced traffic held at empty for several cycles.
        apply_a(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply_a(0, 0, 4'(i + 1), 4'(i + 1));
            check_a($sformatf("hold_empty%0d", i), exp_a(0, 0, 0));
        end

        // Random traffic on A against the model, errors allowed.
        apply_a(1, 0, 0, 0);
        model_step(8, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic       r, f;
            logic [3:0] inc, dec;
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 29) == 0);
            inc = 4'($urandom_range(0, 5));
            dec = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) inc = 4'($urandom);
            if ($urandom_range(0, 19) == 0) dec = 4'($urandom);
            apply_a(r, f, inc, dec);
            model_step(8, r, f, int'(inc), int'(dec));
            check_a($sformatf("rand_a%0d", i), exp_a(m_size, m_ovf, m_unf));
        end
        a_reset = 1;

        // Constrained single-step random on B: never incr at full or decr at empty alone.
        model_step(1, 1, 0, 0, 0);
        b_reset = 1; @(posedge clk); #1;
        b_reset = 0;
        for (int i = 0; i < 10000; i++) begin
            logic inc, dec, f;
            logic [4:0] exp, got;
            inc = 1'($urandom_range(0, 1));
            dec = 1'($urandom_range(0, 1));
            f   = ($urandom_range(0, 99) == 0);
            if (m_size == 1 && inc && !dec) inc = 0;
            if (m_size == 0 && dec && !inc) dec = 0;
            b_flush = f; b_incr = inc; b_decr = dec;
            @(posedge clk); #1;
            model_step(1, 0, f, int'(inc), int'(dec));
            exp = {m_size[0], m_size == 0, m_size == 1, m_ovf, m_unf};
            got = {b_size, b_empty, b_full, b_ovf, b_unf};
            checks++;
            if (got !== exp || b_space !== 1'(1 - m_size)) begin
                errors++;
                $display("FAIL rand_b%0d: got {size,e,f,ovf,unf}=%b space=%b required %b space=%0d",
                         i, got, b_space, exp, 1 - m_size);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
